// File: rtl/answer_frame_scheduler_pkg.sv
// Shared constants and FSM state type for the answer table frame scheduler.
package answer_frame_scheduler_pkg;

    localparam int unsigned NUM_ADDR  = 18;
    localparam logic [4:0]  PARK_ADDR = 5'd31;
    localparam logic [7:0]  HDR_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_HDR,
        S_RD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/answer_frame_scheduler_trigger_timer.sv
// Periodic/manual frame trigger with a single pending slot; a trigger that finds
// the slot already occupied is dropped and reported on frame_ovr.
module answer_frame_scheduler_trigger_timer #(
    parameter int unsigned PERIOD = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic auto_en,
    input  logic clr,
    output logic pending,
    output logic frame_ovr
);

    localparam int unsigned TW = $clog2(PERIOD);

    logic [TW-1:0] timer;
    logic          tick;
    logic          trig;

    assign tick = auto_en && (timer == TW'(PERIOD - 1));
    assign trig = start || tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer     <= '0;
            pending   <= 1'b0;
            frame_ovr <= 1'b0;
        end else begin
            if (!auto_en || tick)
                timer <= '0;
            else
                timer <= timer + TW'(1);
            // A trigger coinciding with the slot being consumed refills it rather than overrunning.
            pending   <= (pending && !clr) || trig;
            frame_ovr <= trig && pending && !clr;
        end
    end

endmodule

// File: rtl/answer_frame_scheduler.sv
// Walks the answer table once per trigger and streams header, data bytes and checksum
// to the UART TX byte interface; also serves single-address host reads from IDLE.
module answer_frame_scheduler #(
    parameter int unsigned       NUM_ADDR  = answer_frame_scheduler_pkg::NUM_ADDR,
    parameter int unsigned       ADDR_W    = 5,
    parameter logic [ADDR_W-1:0] PARK_ADDR = answer_frame_scheduler_pkg::PARK_ADDR,
    parameter int unsigned       RD_LAT    = 2,
    parameter logic [7:0]        HDR_BYTE  = answer_frame_scheduler_pkg::HDR_BYTE,
    parameter int unsigned       PERIOD    = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_en,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_data,
    output logic              host_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_ovr,
    output logic [15:0]       frame_cnt
);

    import answer_frame_scheduler_pkg::*;

    localparam int unsigned       CW   = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ADDR - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n, addr_n;
    logic [7:0]        sum, sum_n, tx_data_n, host_data_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [15:0]       frame_cnt_n;
    logic              tx_valid_n, host_ack_n, frame_done_n;
    logic              pending, clr, accept, rd_ready;

    answer_frame_scheduler_trigger_timer #(
        .PERIOD(PERIOD)
    ) u_trigger_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .auto_en  (auto_en),
        .clr      (clr),
        .pending  (pending),
        .frame_ovr(frame_ovr)
    );

    assign accept   = tx_valid && tx_ready;
    assign rd_ready = (cnt == CW'(RD_LAT));
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        sum_n        = sum;
        cnt_n        = cnt;
        addr_n       = addr;
        tx_valid_n   = tx_valid;
        tx_data_n    = tx_data;
        host_data_n  = host_data;
        host_ack_n   = 1'b0;
        frame_done_n = 1'b0;
        frame_cnt_n  = frame_cnt;
        clr          = 1'b0;
        case (state)
            S_IDLE: begin
                if (host_req) begin
                    state_n = S_HOST;
                    addr_n  = host_addr;
                    cnt_n   = '0;
                end else if (pending) begin
                    state_n    = S_HDR;
                    clr        = 1'b1;
                    tx_valid_n = 1'b1;
                    tx_data_n  = HDR_BYTE;
                end
            end
            S_HOST: begin
                if (rd_ready) begin
                    host_data_n = data_in;
                    host_ack_n  = 1'b1;
                    addr_n      = PARK_ADDR;
                    state_n     = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_HDR: begin
                if (accept) begin
                    tx_valid_n = 1'b0;
                    idx_n      = '0;
                    sum_n      = '0;
                    addr_n     = '0;
                    cnt_n      = '0;
                    state_n    = S_RD;
                end
            end
            S_RD: begin
                if (rd_ready) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = data_in;
                    sum_n      = sum + data_in;
                    state_n    = S_SEND;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SEND: begin
                if (accept) begin
                    tx_valid_n = 1'b0;
                    if (idx == LAST) begin
                        state_n = S_CSUM;
                    end else begin
                        idx_n   = idx + ADDR_W'(1);
                        addr_n  = idx + ADDR_W'(1);
                        cnt_n   = '0;
                        state_n = S_RD;
                    end
                end
            end
            S_CSUM: begin
                // Entered with tx_valid low so the checksum never follows the last byte back-to-back.
                if (!tx_valid) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = sum;
                end else if (accept) begin
                    tx_valid_n = 1'b0;
                    state_n    = S_DONE;
                end
            end
            S_DONE: begin
                addr_n       = PARK_ADDR;
                frame_done_n = 1'b1;
                frame_cnt_n  = frame_cnt + 16'd1;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            sum        <= '0;
            cnt        <= '0;
            addr       <= PARK_ADDR;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            host_data  <= '0;
            host_ack   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            sum        <= sum_n;
            cnt        <= cnt_n;
            addr       <= addr_n;
            tx_valid   <= tx_valid_n;
            tx_data    <= tx_data_n;
            host_data  <= host_data_n;
            host_ack   <= host_ack_n;
            frame_done <= frame_done_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

endmodule

// File: tb/tb_answer_frame_scheduler.sv
// Bench for answer_frame_scheduler: behavioural answer table, byte-stream monitor and
// frame-level reference model; host-read vector table plus directed and random frames.
module tb_answer_frame_scheduler;

    localparam int         NUM_ADDR = 18;
    localparam int         RD_LAT   = 2;
    localparam int         PERIOD   = 40;
    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [4:0] PARK     = 5'd31;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        tx_ready = 1'b0;
    logic        host_req = 1'b0;
    logic [4:0]  host_addr = '0;
    logic [4:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  tx_data;
    logic [7:0]  host_data;
    logic        tx_valid, host_ack, busy, frame_done, frame_ovr;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    answer_frame_scheduler #(
        .PERIOD(PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .auto_en   (auto_en),
        .addr      (addr),
        .data_in   (data_in),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_ack  (host_ack),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_ovr (frame_ovr),
        .frame_cnt (frame_cnt)
    );

    // Answer table: two-stage registered read path.
    logic [7:0] tbl [32];
    logic [7:0] pipe1;
    always @(posedge clk) begin
        pipe1   <= tbl[addr];
        data_in <= pipe1;
    end

    // tx_ready pattern: 0 always ready, 1 one-in-three, 2 random, 3 never ready.
    int mode = 0;
    int ph = 0;
    always @(negedge clk) begin
        case (mode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = (ph == 0); ph = (ph + 1) % 3; end
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    // Stream monitor.
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int stall_viol = 0, b2b_viol = 0, done_seen = 0, ovr_seen = 0, last_visits = 0, txv_seen = 0;
    logic       prev_stall = 1'b0, prev_acc = 1'b0;
    logic [7:0] prev_data = '0;
    logic [4:0] prev_addr = '0;
    always @(posedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_viol++;
            if (prev_acc && tx_valid) b2b_viol++;
            if (frame_done) done_seen++;
            if (frame_ovr) ovr_seen++;
            if (tx_valid) txv_seen++;
            if (addr != prev_addr && addr == 5'(NUM_ADDR - 1)) last_visits++;
            prev_stall = tx_valid && !tx_ready;
            prev_acc   = tx_valid && tx_ready;
            prev_data  = tx_data;
        end
        prev_addr = addr;
    end

    int errors = 0, checks = 0;
    logic [15:0] exp_cnt = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rst_outputs(input string nm);
        check({nm, " addr"}, 32'(addr), 32'(PARK));
        check({nm, " tx_valid"}, 32'(tx_valid), 0);
        check({nm, " tx_data"}, 32'(tx_data), 0);
        check({nm, " host_data"}, 32'(host_data), 0);
        check({nm, " host_ack"}, 32'(host_ack), 0);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " frame_done"}, 32'(frame_done), 0);
        check({nm, " frame_ovr"}, 32'(frame_ovr), 0);
        check({nm, " frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic set_mode(input int m);
        @(posedge clk); #1;
        mode = m;
    endtask

    // Expected stream: per frame, header, every table entry in address order, then
    // the 8-bit sum of the data bytes.
    task automatic build_exp(input int nfr);
        int s;
        exp_q.delete();
        repeat (nfr) begin
            s = 0;
            exp_q.push_back(HDR);
            for (int a = 0; a < NUM_ADDR; a++) begin
                exp_q.push_back(tbl[a]);
                s = s + int'(tbl[a]);
            end
            exp_q.push_back(8'(s % 256));
        end
    endtask

    task automatic wait_frames(input int d0, input int n);
        for (int i = 0; i < 4000 * n; i++) begin
            @(posedge clk); #1;
            if (done_seen >= d0 + n) break;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_frames(input string nm, input int nfr, input int d0, input int v0,
                                input int s0, input int b0);
        int n, mism;
        build_exp(nfr);
        exp_cnt = exp_cnt + 16'(nfr);
        check({nm, " byte count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        mism = 0;
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) mism++;
        check({nm, " byte mismatches"}, mism, 0);
        check({nm, " frame_done pulses"}, done_seen - d0, nfr);
        check({nm, " frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        check({nm, " last addr visits"}, last_visits - v0, nfr);
        check({nm, " stall stability"}, stall_viol - s0, 0);
        check({nm, " back-to-back"}, b2b_viol - b0, 0);
        check({nm, " busy after"}, 32'(busy), 0);
        check({nm, " parked addr"}, 32'(addr), 32'(PARK));
    endtask

    task automatic run_frame(input string nm);
        int d0, v0, s0, b0;
        d0 = done_seen; v0 = last_visits; s0 = stall_viol; b0 = b2b_viol;
        @(negedge clk);
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frames(d0, 1);
        check_frames(nm, 1, d0, v0, s0, b0);
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] d, output int lat);
        int t0;
        t0 = txv_seen;
        lat = -1;
        d = '0;
        @(negedge clk);
        host_req = 1'b1;
        host_addr = a;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (host_ack) begin
                lat = i;
                d = host_data;
                break;
            end
        end
        @(negedge clk);
        host_req = 1'b0;
        check("host no tx_valid", txv_seen - t0, 0);
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < 32; a++) tbl[a] = 8'((a * 10) % 256);
        tbl[16] = 8'h33;
        tbl[17] = 8'h00;
    endtask

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } hvec_t;
    hvec_t hv [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hd;
        int lat, d0, v0, s0, b0, o0, cyc, ntrig, ackwait;
        logic [4:0] ra;

        hv[0] = '{5'd5,  8'd50};
        hv[1] = '{5'd0,  8'd0};
        hv[2] = '{5'd16, 8'h33};
        hv[3] = '{5'd17, 8'h00};
        hv[4] = '{5'd15, 8'd150};
        hv[5] = '{5'd31, 8'd54};

        fill_pattern();
        repeat (3) @(posedge clk);
        #1;
        check_rst_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            host_read(hv[i].a, hd, lat);
            check("host latency", lat, RD_LAT + 1);
            check("host data", 32'(hd), 32'(hv[i].d));
        end
        @(posedge clk); #1;
        check("host_ack single pulse", 32'(host_ack), 0);

        set_mode(0);
        run_frame("frame ready");
        set_mode(1);
        run_frame("frame 1-in-3");
        set_mode(0);

        // Simultaneous start and host request: host read first, then the frame.
        d0 = done_seen; v0 = last_visits; s0 = stall_viol; b0 = b2b_viol;
        @(negedge clk);
        got.delete();
        start = 1'b1;
        host_req = 1'b1;
        host_addr = 5'd5;
        @(negedge clk);
        start = 1'b0;
        ackwait = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (host_ack) begin ackwait = i; break; end
        end
        check("start+host ack seen", 32'(ackwait >= 0), 1);
        check("start+host data", 32'(host_data), 50);
        check("start+host no bytes yet", got.size(), 0);
        @(negedge clk);
        host_req = 1'b0;
        wait_frames(d0, 1);
        check_frames("start+host frame", 1, d0, v0, s0, b0);

        // Randomised table contents and tx_ready patterns.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 32; a++) tbl[a] = 8'($urandom);
            set_mode(int'($urandom_range(0, 2)));
            run_frame("random frame");
            for (int k = 0; k < 3; k++) begin
                ra = 5'($urandom_range(0, 31));
                host_read(ra, hd, lat);
                check("random host data", 32'(hd), 32'(tbl[ra]));
            end
        end

        // Periodic triggers with the UART stalled: one frame starts, one waits, the rest drop.
        fill_pattern();
        set_mode(3);
        d0 = done_seen; v0 = last_visits; s0 = stall_viol; b0 = b2b_viol; o0 = ovr_seen;
        @(negedge clk);
        got.delete();
        auto_en = 1'b1;
        cyc = 125;
        repeat (cyc) @(negedge clk);
        auto_en = 1'b0;
        ntrig = cyc / PERIOD;
        check("auto overrun pulses", ovr_seen - o0, (ntrig > 2) ? ntrig - 2 : 0);
        check("auto busy while stalled", 32'(busy), 1);
        check("auto header held", 32'(tx_data), 32'(HDR));
        set_mode(0);
        wait_frames(d0, 2);
        check_frames("auto frames", 2, d0, v0, s0, b0);

        // Reset in the middle of a stalled data byte.
        set_mode(0);
        @(negedge clk);
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (got.size() >= 3) break;
        end
        set_mode(3);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx_valid && !tx_ready) break;
        end
        check("mid-frame stalled", 32'(tx_valid && busy), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_rst_outputs("mid-frame reset");
        @(negedge clk);
        rst = 1'b1;
        o0 = txv_seen;
        set_mode(0);
        repeat (10) @(posedge clk);
        #1;
        check("no tx after reset", txv_seen - o0, 0);
        exp_cnt = '0;
        run_frame("frame after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
